// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: drives a req/gnt/rvalid bus, stalls the
// pipeline until the access completes, and returns aligned, extended load data.
module mem_access_unit #(
   parameter int WIDTH     = 32,
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [1:0]       mem_size_i,
   input  logic             mem_unsigned_i,
   input  logic [WIDTH-1:0] addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] read_data_o,
   output logic             done_o,
   output logic             stall_o,
   output logic             misalign_o,
   output logic             bus_err_o,
   output logic             dmem_req_o,
   output logic             dmem_we_o,
   output logic [WIDTH-1:0] dmem_addr_o,
   output logic [3:0]       dmem_be_o,
   output logic [WIDTH-1:0] dmem_wdata_o,
   input  logic             dmem_gnt_i,
   input  logic             dmem_rvalid_i,
   input  logic [WIDTH-1:0] dmem_rdata_i
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 we_q, uns_q;
   logic [1:0]           size_q, off_q;
   logic [WIDTH-1:0]     addr_q, wdata_q;
   logic [3:0]           be_q;
   logic                 done_q, done_d, err_q, err_d;
   logic [WIDTH-1:0]     rdata_q, rdata_d;

   logic             access, is_half, is_word, idle, start, timeout;
   logic [3:0]       be_c;
   logic [WIDTH-1:0] wdata_c, load_c;
   logic [7:0]       byte_lane;
   logic [15:0]      half_lane;

   assign access  = mem_read_i | mem_write_i;
   assign is_half = (mem_size_i == 2'b01);
   assign is_word = mem_size_i[1];
   assign idle    = (state_q == S_IDLE);
   assign misalign_o = idle & access &
                       ((is_half & addr_i[0]) | (is_word & (addr_i[1:0] != 2'b00)));
   assign start   = idle & access & ~misalign_o;
   // Counter value CNT_LAST marks the TIMEOUT-th cycle spent in REQ/WAIT.
   assign timeout = (cnt_q == CNT_LAST);

   always_comb begin
      be_c    = 4'b0001 << addr_i[1:0];
      wdata_c = {(WIDTH/8){wdata_i[7:0]}};
      if (is_word) begin
         be_c    = 4'b1111;
         wdata_c = wdata_i;
      end else if (is_half) begin
         be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
         wdata_c = {(WIDTH/16){wdata_i[15:0]}};
      end
   end

   always_comb begin
      byte_lane = dmem_rdata_i[{off_q, 3'b000} +: 8];
      half_lane = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (size_q)
         2'b00:   load_c = uns_q ? {{(WIDTH-8){1'b0}}, byte_lane}
                                 : {{(WIDTH-8){byte_lane[7]}}, byte_lane};
         2'b01:   load_c = uns_q ? {{(WIDTH-16){1'b0}}, half_lane}
                                 : {{(WIDTH-16){half_lane[15]}}, half_lane};
         default: load_c = dmem_rdata_i;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      rdata_d = '0;
      case (state_q)
         S_IDLE: if (start) begin
            state_d = S_REQ;
            cnt_d   = '0;
         end
         S_REQ: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (dmem_gnt_i) begin
               state_d = we_q ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (timeout) begin
               state_d = S_DONE;
               err_d   = 1'b1;
            end else if (dmem_rvalid_i) begin
               state_d = S_DONE;
               rdata_d = load_c;
            end
         end
         default: state_d = S_IDLE;
      endcase
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Request capture: a simultaneous read+write is a read.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         off_q   <= 2'b00;
         addr_q  <= '0;
         be_q    <= 4'b0000;
         wdata_q <= '0;
      end else if (start) begin
         we_q    <= mem_write_i & ~mem_read_i;
         uns_q   <= mem_unsigned_i;
         size_q  <= mem_size_i;
         off_q   <= addr_i[1:0];
         addr_q  <= {addr_i[WIDTH-1:2], 2'b00};
         be_q    <= be_c;
         wdata_q <= wdata_c;
      end
   end

   assign stall_o      = start | (state_q == S_REQ) | (state_q == S_WAIT);
   assign dmem_req_o   = (state_q == S_REQ);
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;
   assign done_o       = done_q;
   assign bus_err_o    = err_q;
   assign read_data_o  = rdata_q;
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit in the 5-stage MIPS pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Takes load/store requests, drives a variable-latency data-memory bus with a req/gnt/rvalid handshake, and stalls the pipeline until the access completes.
- Returns aligned, sign- or zero-extended load data for the writeback stage, and flags misaligned accesses and bus timeouts.

Parameters:
- WIDTH, 32, data and address width in bits.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted with a bus error.
- CNT_WIDTH, 8, width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT.

Ports:
- clk_i  in  1  clock; all state is updated on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- mem_read_i  in  1  load request from EX/MEM.
- mem_write_i  in  1  store request from EX/MEM.
- mem_size_i  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- mem_unsigned_i  in  1  1 = zero-extend load data, 0 = sign-extend.
- addr_i  in  WIDTH  byte address (the ALU result).
- wdata_i  in  WIDTH  store data (rt value).
- read_data_o  out  WIDTH  extracted load data, valid while done_o=1.
- done_o  out  1  one-cycle pulse when an access completes.
- stall_o  out  1  freeze request to the hazard unit.
- misalign_o  out  1  misaligned access flag (combinational).
- bus_err_o  out  1  one-cycle pulse when an access is aborted on timeout.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  WIDTH  word-aligned address: addr with bits [1:0] forced to 0.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  WIDTH  lane-replicated store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  WIDTH  read data word.

Behaviour:
- Reset: state=IDLE, counter=0, all outputs 0, captured request registers 0. A reset in any state aborts the access immediately and drops dmem_req_o with no completion pulse.
- Access decode:
  - access = mem_read_i | mem_write_i.
  - If both are set, the access is a read and the write is ignored.
- Misalignment:
  - misalign_o = access & ((half & addr[0]) | (word & addr[1:0]!=0)), evaluated in IDLE only.
  - A misaligned access issues no bus request, leaves stall_o at 0, and changes no state.
- IDLE:
  - stall_o = access & ~misalign_o (combinational, same cycle).
  - On that condition, capture we, size, unsigned flag, addr[1:0], addr, be and replicated wdata; next state REQ.
- REQ:
  - dmem_req_o=1; dmem_* outputs come from the captured registers and stay stable until gnt.
  - stall_o=1.
  - On dmem_gnt_i: a write goes to DONE, a read goes to WAIT.
  - dmem_rvalid_i is ignored in REQ.
- WAIT:
  - dmem_req_o=0, stall_o=1.
  - On dmem_rvalid_i: latch dmem_rdata_i; next state DONE.
- DONE:
  - done_o=1, stall_o=0, read_data_o = extracted data (0 for writes).
  - Next state IDLE unconditionally. The inputs still hold the completing instruction, so no new access is accepted in DONE.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT, go to DONE with bus_err_o=1 and read_data_o=0.
  - A gnt or rvalid arriving in that same cycle is ignored.
- Byte enables:
  - byte: 0001 shifted left by addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- Store data: byte is replicated 4 times; half is replicated 2 times; word passes through unchanged.
- Load extraction:
  - byte lane = rdata[8*addr[1:0] +: 8].
  - half lane = addr[1] ? rdata[31:16] : rdata[15:0].
  - Sign- or zero-extend the lane to WIDTH per the unsigned flag.
- Latency:
  - Write with same-cycle gnt: 3 cycles (IDLE to DONE), stall asserted for 2 of them.
  - Read with gnt at cycle 1 and rvalid at cycle 2: done_o at cycle 3.
- Outputs other than stall_o, misalign_o and dmem_* are registered.

Test Plan:
- lb, addr=0x103, unsigned=0, gnt immediate, rvalid next cycle with rdata=0x80FF_1234 -> dmem_addr=0x100, be=0001<<3 = 1000, read_data_o=0xFFFF_FF80, done_o pulses once, stall high for exactly 3 cycles.
- sh, addr=0x202, wdata=0x0000_ABCD, gnt delayed 4 cycles -> dmem_req_o held 5 cycles with stable addr=0x200, be=1100, wdata=0xABCD_ABCD, then done_o; read_data_o=0.
- lhu, addr=0x301 -> misalign_o=1 same cycle, dmem_req_o never asserted, stall_o=0, state stays IDLE.
- lw, gnt given, rvalid never arrives, TIMEOUT=8 -> bus_err_o pulse after 8 cycles in REQ/WAIT, read_data_o=0, returns to IDLE.
- rst_n_i pulsed low while in WAIT -> all outputs 0 immediately; the following lw=0x12345678 at 0x400 completes normally with read_data_o=0x1234_5678.
- mem_read_i and mem_write_i both high -> dmem_we_o=0 and a normal read completes.
